// File: rtl/render_arb_pkg.sv
// Shared types and helpers for the scan-line fill engine arbiter.
package render_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_NREQ = 8;
    localparam int unsigned MAX_IDXW = 3;

    // Idle interval is empty (x0 > x1); truncated to the coordinate width at use.
    localparam logic [31:0] IDLE_X0 = 32'hFFFF_FFFF;
    localparam logic [31:0] IDLE_X1 = 32'h0000_0000;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_IDXW-1:0] idx);
        logic [MAX_NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic                    o_found,
    output logic [$clog2(NREQ)-1:0] o_idx
);
    localparam int unsigned IDXW = $clog2(NREQ);

    int w_pos;

    // Scan from farthest to nearest so the nearest hit to the pointer wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_pos = (int'(i_ptr) + k) % int'(NREQ);
            if (i_req[IDXW'(w_pos)]) begin
                o_found = 1'b1;
                o_idx   = IDXW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/scan_arbiter.sv
// Round-robin arbiter sharing one scan-line fill engine between NREQ renderers.
// Define SCAN_ARB_GRANT_COUNT_EN to add per-requester saturating grant counters.
module scan_arbiter
    import render_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned CORDW = 10
`ifdef SCAN_ARB_GRANT_COUNT_EN
    ,
    parameter int unsigned CNTW  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CORDW-1:0]   req_x0,
    input  logic [NREQ*CORDW-1:0]   req_x1,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    busy,
    output logic                    scan_start,
    input  logic [CORDW-1:0]        scan_y,
    input  logic                    scan_done,
`ifdef SCAN_ARB_GRANT_COUNT_EN
    input  logic                    cnt_clr,
    output logic [NREQ*CNTW-1:0]    grant_cnt,
`endif
    output logic [CORDW-1:0]        scan_x0,
    output logic [CORDW-1:0]        scan_x1,
    output logic [CORDW-1:0]        req_y
);
    localparam int unsigned IDXW = $clog2(NREQ);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [NREQ-1:0]  r_grant,     w_grant_nxt;
    logic [IDXW-1:0]  r_grant_idx, w_grant_idx_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_start,     w_start_nxt;
    logic [NREQ-1:0]  r_ack,       w_ack_nxt;
    logic [IDXW-1:0]  r_ptr,       w_ptr_nxt;

    logic [NREQ-1:0]  w_req_eff;
    logic             w_found;
    logic [IDXW-1:0]  w_win_idx;
    logic [CORDW-1:0] w_x0;
    logic [CORDW-1:0] w_x1;

    // The requester being acked this cycle cannot win again immediately.
    assign w_req_eff = req & ~r_ack;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req   (w_req_eff),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_win_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_ack       <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_start     <= w_start_nxt;
            r_ack       <= w_ack_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_found)   w_state_nxt = START;
            START:                    w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (scan_done) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; start and ack are single-cycle pulses.
    always_comb begin
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_busy_nxt      = r_busy;
        w_start_nxt     = 1'b0;
        w_ack_nxt       = '0;
        w_ptr_nxt       = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt     = NREQ'(onehot(MAX_IDXW'(w_win_idx)));
                    w_grant_idx_nxt = w_win_idx;
                    w_busy_nxt      = 1'b1;
                    w_start_nxt     = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (scan_done) begin
                    w_ack_nxt   = NREQ'(onehot(MAX_IDXW'(r_grant_idx)));
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = (r_grant_idx == IDXW'(NREQ - 1)) ? '0
                                                                   : r_grant_idx + IDXW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_x0 = CORDW'(IDLE_X0);
        w_x1 = CORDW'(IDLE_X1);
        if (|r_grant) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (r_grant_idx == IDXW'(i)) begin
                    w_x0 = req_x0[i*CORDW +: CORDW];
                    w_x1 = req_x1[i*CORDW +: CORDW];
                end
            end
        end
    end

`ifdef SCAN_ARB_GRANT_COUNT_EN
    logic [CNTW-1:0] r_cnt [NREQ];
    logic            w_issue;

    assign w_issue = (r_state == IDLE) && w_found;

    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!rst_n || cnt_clr) begin
                r_cnt[i] <= '0;
            end else if (w_issue && (w_win_idx == IDXW'(i)) && (r_cnt[i] != '1)) begin
                r_cnt[i] <= r_cnt[i] + CNTW'(1);
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            grant_cnt[i*CNTW +: CNTW] = r_cnt[i];
        end
    end
`endif

    assign grant      = r_grant;
    assign grant_idx  = r_grant_idx;
    assign busy       = r_busy;
    assign scan_start = r_start;
    assign ack        = r_ack;
    assign scan_x0    = w_x0;
    assign scan_x1    = w_x1;
    assign req_y      = scan_y;

endmodule

// File: tb/tb_scan_arbiter.sv
// Self-checking bench for scan_arbiter: directed scenarios plus randomized traffic
// checked against a pass-level reference model.
module tb_scan_arbiter;
    localparam int NREQ  = 4;
    localparam int CORDW = 10;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*CORDW-1:0] req_x0, req_x1;
    logic [NREQ-1:0]       ack, grant;
    logic [1:0]            grant_idx;
    logic                  busy, scan_start;
    logic [CORDW-1:0]      scan_y;
    logic                  scan_done;
    logic [CORDW-1:0]      scan_x0, scan_x1, req_y;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owner of the engine (-1 = none), cycles since its grant,
    // round-robin pointer and the requester acked in the current cycle.
    int m_owner = -1;
    int m_age   = 0;
    int m_ptr   = 0;
    int m_ack   = -1;
    int acks_seen [NREQ];

    scan_arbiter #(.NREQ(NREQ), .CORDW(CORDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_x0     (req_x0),
        .req_x1     (req_x1),
        .ack        (ack),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .busy       (busy),
        .scan_start (scan_start),
        .scan_y     (scan_y),
        .scan_done  (scan_done),
        .scan_x0    (scan_x0),
        .scan_x1    (scan_x1),
        .req_y      (req_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    function automatic void model_step();
        int w;
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_ack = -1;
            return;
        end
        if (m_owner < 0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int p;
                p = (m_ptr + k) % NREQ;
                if (w < 0 && req[p] && p != m_ack) w = p;
            end
            m_ack = -1;
            if (w >= 0) begin
                m_owner = w;
                m_age   = 0;
            end
        end else begin
            m_ack = -1;
            if (m_age >= 1 && scan_done) begin
                m_ack   = m_owner;
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end
    endfunction

    task automatic check_all();
        chk("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("scan_start", 32'(scan_start), 32'(m_owner >= 0 && m_age == 0));
        chk("ack", 32'(ack), (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
        chk("req_y", 32'(req_y), 32'(scan_y));
        if (m_owner >= 0) begin
            chk("grant_idx", 32'(grant_idx), 32'(m_owner));
            chk("scan_x0", 32'(scan_x0), 32'(req_x0[m_owner*CORDW +: CORDW]));
            chk("scan_x1", 32'(scan_x1), 32'(req_x1[m_owner*CORDW +: CORDW]));
        end else begin
            chk("idle_x0", 32'(scan_x0), 32'd1023);
            chk("idle_x1", 32'(scan_x1), 32'd0);
        end
        for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) acks_seen[i]++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (scan_start === 1'b1) ok = 1'b1;
        end
        chk("start_timeout", 32'(ok), 32'd1);
    endtask

    task automatic finish_pass();
        tick();
        scan_done = 1'b1;
        tick();
        scan_done = 1'b0;
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; req = '0; scan_done = 1'b0; scan_y = '0;
        req_x0 = '0; req_x1 = '0;
        for (int i = 0; i < NREQ; i++) acks_seen[i] = 0;

        // Reset state
        tick(); tick();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Idle: empty interval, no start pulse
        repeat (3) tick();
        chk("idle_x0_dir", 32'(scan_x0), 32'd1023);
        chk("idle_start_dir", 32'(scan_start), 32'd0);

        // Single requester, held through its ack cycle
        req = 4'b0001;
        tick();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_start", 32'(scan_start), 32'd1);
        tick();
        finish_pass();
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_busy", 32'(busy), 32'd0);
        tick();
        chk("no_regrant_ack_cycle", 32'(grant), 32'd0);
        tick();
        chk("regrant_next", 32'(grant), 32'h1);
        tick();
        finish_pass();
        req = '0;
        tick();

        // scan_done while idle is ignored
        scan_done = 1'b1;
        tick();
        scan_done = 1'b0;
        tick();
        chk("idle_done_no_ack", 32'(ack), 32'd0);

        // Interval mux for requester 2 and y broadcast
        req_x0 = {10'd7, 10'd100, 10'd9, 10'd11};
        req_x1 = {10'd8, 10'd200, 10'd10, 10'd12};
        req = 4'b0100;
        tick();
        scan_y = 10'd37; #1;
        chk("mux_x0", 32'(scan_x0), 32'd100);
        chk("mux_x1", 32'(scan_x1), 32'd200);
        chk("req_y_37", 32'(req_y), 32'd37);
        tick();
        scan_y = 10'd500; #1;
        chk("req_y_500", 32'(req_y), 32'd500);
        finish_pass();
        req = '0;
        tick();

        // Fairness: all requesters held high for 8 passes from pointer 0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) acks_seen[i] = 0;
        req = 4'b1111;
        for (int p = 0; p < 8; p++) begin
            wait_start(ok);
            chk("rr_order", 32'(grant_idx), 32'(p % NREQ));
            tick();
            finish_pass();
            if (p == 7) req = '0;
        end
        repeat (2) tick();
        for (int i = 0; i < NREQ; i++) chk("acks_per_req", 32'(acks_seen[i]), 32'd2);

        // Reset during WAIT_DONE returns pointer to 0
        req = 4'b0010;
        wait_start(ok);
        tick();
        finish_pass();
        req = 4'b1000;
        tick(); tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("midreset_grant", 32'(grant), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("midreset_ptr0", 32'(grant), 32'h1);
        tick();
        finish_pass();
        req = '0;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
            end
            if (m_ack >= 0 && $urandom_range(0, 1) == 1) req[m_ack] = 1'b0;
            if (m_owner >= 0 && $urandom_range(0, 40) == 0) req[m_owner] = 1'b0;
            req_x0 = {$urandom, $urandom};
            req_x1 = {$urandom, $urandom};
            scan_y = CORDW'($urandom);
            if (m_owner >= 0 && m_age >= 1) scan_done = ($urandom_range(0, 2) == 0);
            else if (m_owner >= 0)          scan_done = ($urandom_range(0, 5) == 0);
            else                            scan_done = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
